// File: rtl/conversor_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter and the
// 7-segment digit decoders that consume its output codes.
package conversor_bcd_seq_pkg;

   // Binary width kept after the range check (2^17 > 99999)
   localparam int N_BITS    = 17;
   // Number of BCD digits produced
   localparam int N_DIGITOS = 5;
   // Width of the packed BCD register
   localparam int BCD_W     = 4 * N_DIGITOS;
   // Width of the shift counter
   localparam int CNT_W     = 5;

   // Largest value the five-digit display can show
   localparam logic [31:0] LIMITE_DISPLAY = 32'd99999;

   // Digit codes understood by the segment decoder besides 0..9
   localparam logic [3:0] DIGITO_APAGADO = 4'hF;
   localparam logic [3:0] DIGITO_ERRO    = 4'hE;

   // Counter value seen on the last shift edge
   localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(N_BITS - 1);

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      CONVERTE = 2'd1,
      FIM      = 2'd2
   } estado_t;

   // Replicates one digit code across every digit position
   function automatic logic [BCD_W-1:0] repete_digito(input logic [3:0] codigo);
      return {N_DIGITOS{codigo}};
   endfunction

endpackage

// File: rtl/conversor_bcd_seq_corrige_digito.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module corrige_digito (
   input  logic [3:0] digito_i,
   output logic [3:0] digito_o
);

   // Add 3 to nibbles >= 5, pass smaller nibbles through unchanged
   always_comb begin
      digito_o = digito_i;
      if (digito_i >= 4'd5) begin
         digito_o = digito_i + 4'd3;
      end else begin
         digito_o = digito_i;
      end
   end

endmodule

// File: rtl/conversor_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3). Accepts a 32-bit value,
// range-checks it against the display limit and produces five BCD digits,
// units first. Results are held until the next conversion finishes.
module conversor_bcd_seq
   import conversor_bcd_seq_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] valor,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic [3:0]  digito1,
   output logic [3:0]  digito2,
   output logic [3:0]  digito3,
   output logic [3:0]  digito4,
   output logic [3:0]  digito5
);

   estado_t            estado_q, estado_d;
   logic [N_BITS-1:0]  bin_q, bin_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               erro_q, erro_d;
   logic [BCD_W-1:0]   dig_q, dig_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [BCD_W-1:0]   bcd_corr_s;

   // One correction cell per BCD digit; nibbles are corrected independently
   for (genvar i = 0; i < N_DIGITOS; i++) begin : g_corrige
      corrige_digito u_corrige (
         .digito_i (bcd_q[4*i +: 4]),
         .digito_o (bcd_corr_s[4*i +: 4])
      );
   end

   // Next-state and datapath logic for the idle / convert / finish sequence
   always_comb begin
      estado_d = estado_q;
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      cnt_d    = cnt_q;
      erro_d   = erro_q;
      dig_d    = dig_q;
      ovf_d    = ovf_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (estado_q)
         OCIOSO: begin
            if (start) begin
               busy_d = 1'b1;
               if (valor > LIMITE_DISPLAY) begin
                  // Out of range: skip the shifts and report the error code
                  erro_d   = 1'b1;
                  estado_d = FIM;
               end else begin
                  // In range, so the upper bits are zero and truncation is safe
                  bin_d    = valor[N_BITS-1:0];
                  bcd_d    = {BCD_W{1'b0}};
                  cnt_d    = {CNT_W{1'b0}};
                  erro_d   = 1'b0;
                  estado_d = CONVERTE;
               end
            end else begin
               busy_d   = 1'b0;
               estado_d = OCIOSO;
            end
         end

         CONVERTE: begin
            busy_d = 1'b1;
            // Correct every nibble first, then shift {bcd, bin} left by one
            bcd_d  = {bcd_corr_s[BCD_W-2:0], bin_q[N_BITS-1]};
            bin_d  = {bin_q[N_BITS-2:0], 1'b0};
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == CNT_ULTIMO) begin
               estado_d = FIM;
            end else begin
               estado_d = CONVERTE;
            end
         end

         FIM: begin
            if (erro_q) begin
               dig_d = repete_digito(DIGITO_ERRO);
               ovf_d = 1'b1;
            end else begin
               dig_d = bcd_q;
               ovf_d = 1'b0;
            end
            done_d   = 1'b1;
            busy_d   = 1'b0;
            estado_d = OCIOSO;
         end

         default: begin
            busy_d   = 1'b0;
            estado_d = OCIOSO;
         end
      endcase
   end

   // State register with synchronous reset; reset aborts any conversion
   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q <= OCIOSO;
         bin_q    <= {N_BITS{1'b0}};
         bcd_q    <= {BCD_W{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
         erro_q   <= 1'b0;
         dig_q    <= repete_digito(DIGITO_APAGADO);
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         cnt_q    <= cnt_d;
         erro_q   <= erro_d;
         dig_q    <= dig_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = ovf_q;
   assign digito1  = dig_q[3:0];
   assign digito2  = dig_q[7:4];
   assign digito3  = dig_q[11:8];
   assign digito4  = dig_q[15:12];
   assign digito5  = dig_q[19:16];

endmodule

// File: tb/tb_conversor_bcd_seq.sv
// Directed self-checking bench for conversor_bcd_seq.
module tb_conversor_bcd_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] valor;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [3:0]  digito1, digito2, digito3, digito4, digito5;

   int errors;
   int checks;

   conversor_bcd_seq dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .valor    (valor),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .digito1  (digito1),
      .digito2  (digito2),
      .digito3  (digito3),
      .digito4  (digito4),
      .digito5  (digito5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Digits packed as {d5,d4,d3,d2,d1}, so 12345 reads as 20'h12345
   function automatic logic [19:0] digitos();
      return {digito5, digito4, digito3, digito2, digito1};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts a conversion and waits (bounded) for done; checks latency and result
   task automatic converte(input string tag, input logic [31:0] v,
                           input logic [19:0] exp_dig, input logic exp_ovf,
                           input int exp_lat);
      int lat;
      int busyc;
      start = 1'b1;
      valor = v;
      tick();
      start = 1'b0;
      lat   = 0;
      busyc = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) busyc++;
         tick();
         lat++;
      end
      chk({tag, "_done"},     {31'd0, done},     32'd1);
      chk({tag, "_latency"},  lat,               exp_lat);
      chk({tag, "_busy_cyc"}, busyc,             exp_lat);
      chk({tag, "_busy_end"}, {31'd0, busy},     32'd0);
      chk({tag, "_digits"},   {12'd0, digitos()}, {12'd0, exp_dig});
      chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
   endtask

   initial begin
      int ndone;
      int lat;
      logic [19:0] dig_cap;

      errors = 0;
      checks = 0;
      reset  = 1'b1;
      start  = 1'b0;
      valor  = 32'd0;

      // Reset held for two cycles
      tick();
      tick();
      reset = 1'b0;
      chk("rst_digits",   {12'd0, digitos()}, 32'h000F_FFFF);
      chk("rst_overflow", {31'd0, overflow},  32'd0);
      chk("rst_busy",     {31'd0, busy},      32'd0);
      chk("rst_done",     {31'd0, done},      32'd0);

      // Plain conversion; done lasts one cycle and results hold afterwards
      converte("v12345", 32'd12345, 20'h12345, 1'b0, 18);
      tick();
      chk("v12345_done_pulse", {31'd0, done}, 32'd0);
      tick();
      tick();
      chk("v12345_hold", {12'd0, digitos()}, 32'h0001_2345);

      // Largest value, then zero started during the done cycle
      converte("v99999", 32'd99999, 20'h99999, 1'b0, 18);
      converte("v0_b2b", 32'd0,     20'h00000, 1'b0, 18);

      // Just past the limit takes the overflow path; next value recovers
      converte("v100000", 32'd100000, 20'hEEEEE, 1'b1, 1);
      tick();
      converte("v7", 32'd7, 20'h00007, 1'b0, 18);
      tick();

      // Value wider than 17 bits whose low bits alias a legal number
      converte("v2p17", 32'h0002_0005, 20'hEEEEE, 1'b1, 1);
      tick();

      // start pulsed mid-conversion must be ignored
      start = 1'b1;
      valor = 32'd42;
      tick();
      start   = 1'b0;
      ndone   = 0;
      lat     = 0;
      dig_cap = 20'h0;
      for (int k = 1; k <= 30; k++) begin
         if (k == 5) begin
            start = 1'b1;
            valor = 32'd500;
         end
         tick();
         start = 1'b0;
         if (done === 1'b1) begin
            ndone++;
            if (lat == 0) begin
               lat     = k;
               dig_cap = digitos();
            end
         end
      end
      chk("ign_ndone",   ndone,             32'd1);
      chk("ign_latency", lat,               32'd18);
      chk("ign_digits",  {12'd0, dig_cap},  32'h0000_0042);
      chk("ign_overflow", {31'd0, overflow}, 32'd0);

      // Reset in the middle of a conversion aborts it
      start = 1'b1;
      valor = 32'd54321;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 9; k++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_digits", {12'd0, digitos()}, 32'h000F_FFFF);
      chk("abort_busy",   {31'd0, busy},      32'd0);
      chk("abort_done",   {31'd0, done},      32'd0);
      ndone = 0;
      for (int k = 1; k <= 25; k++) begin
         tick();
         if (done === 1'b1) ndone++;
      end
      chk("abort_no_done", ndone, 32'd0);
      chk("abort_still_blank", {12'd0, digitos()}, 32'h000F_FFFF);

      converte("v54321", 32'd54321, 20'h54321, 1'b0, 18);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
